vec_result_collector: RTL and testbench

Downstream consumer of the FP multiplier pipeline output register stage (result word plus exception flag). Tracks which pipeline slots carry real operand pairs with a latency-matched valid delay line, and writes each real result into a VEC_LEN-entry result bank with per-element exception flags. Counts exceptions and signals vector completion to the top-level sequencer. Provides a registered read port for result readback.

---
 rtl/vfpm_pkg.sv | 17 +
 rtl/vec_result_collector_delay.sv | 29 ++
 rtl/vec_result_collector.sv | 138 +++++++++++++
 tb/tb_vec_result_collector.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfpm_pkg.sv
// Shared constants and collector state encoding for the FP multiplier
// vector result path.
package vfpm_pkg;

    localparam int VEC_LEN = 32;   // elements per vector (power of two)
    localparam int LAT     = 4;    // issue -> result latency of the multiplier pipe
    localparam int W       = 32;   // result word width (IEEE-754 single)
    localparam int AW      = 5;    // log2(VEC_LEN)

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } coll_state_e;

endpackage

// File: rtl/vec_result_collector_delay.sv
// Latency-matched valid tag delay line: a 1 entering at din appears at
// dout exactly LAT enabled cycles later.
module valid_delay_line #(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [LAT-1:0] r_stage;

    // Shift register; reset discards every in-flight tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage <= '0;
        end else if (en) begin
            for (int i = LAT - 1; i > 0; i--) begin
                r_stage[i] <= r_stage[i-1];
            end
            r_stage[0] <= din;
        end
    end

    assign dout = r_stage[LAT-1];

endmodule

// File: rtl/vec_result_collector.sv
// Collects one vector of multiplier results into a dense result bank with
// per-element exception flags, counts exceptions and reports completion.
module vec_result_collector
    import vfpm_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          issue_valid,
    input  logic [W-1:0]  res_data,
    input  logic          res_exc,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic          rd_exc,
    output logic [AW:0]   exc_count,
    output logic          issue_overrun,
    output logic          busy,
    output logic          done
);

    localparam logic [AW:0] LEN_C  = (AW+1)'(VEC_LEN);
    localparam logic [AW:0] LAST_C = (AW+1)'(VEC_LEN - 1);

    coll_state_e        r_state;
    coll_state_e        w_state_next;
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_issue_cnt;
    logic [AW:0]        r_exc_count;
    logic [VEC_LEN-1:0] r_flag;
    logic [W-1:0]       r_bank [VEC_LEN];
    logic               r_overrun;
    logic               r_busy;
    logic               r_done;
    logic [W-1:0]       r_rd_data;
    logic               r_rd_exc;

    logic w_active;
    logic w_start_acc;
    logic w_issue_acc;
    logic w_dl_clr;
    logic w_tap;
    logic w_capture;
    logic w_last_capture;

    // Control qualifiers shared by the FSM and the datapath.
    always_comb begin
        w_active       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
        w_start_acc    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_issue_acc    = (r_state == ST_RUN) && issue_valid && (r_issue_cnt < LEN_C);
        w_dl_clr       = reset || w_start_acc;
        w_capture      = w_active && w_tap;
        w_last_capture = w_capture && (r_wr_ptr == LAST_C);
    end

    // Tags ride the delay line so the tap lines up with res_data.
    valid_delay_line #(
        .LAT (LAT)
    ) u_valid_delay_line (
        .clk   (clk),
        .reset (w_dl_clr),
        .en    (w_active),
        .din   (w_issue_acc),
        .dout  (w_tap)
    );

    // Next-state logic; RUN hands over to DRAIN on the edge of the last issue.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_RUN;
            ST_RUN:   if (w_issue_acc && (r_issue_cnt == LAST_C)) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_last_capture || (r_wr_ptr == LEN_C)) w_state_next = ST_DONE;
            ST_DONE:  if (start) w_state_next = ST_RUN;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Counters, flags and status; busy/done are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_issue_cnt <= '0;
            r_exc_count <= '0;
            r_flag      <= '0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy <= (w_state_next == ST_RUN) || (w_state_next == ST_DRAIN);
            r_done <= (w_state_next == ST_DONE);
            if (w_start_acc) begin
                r_wr_ptr    <= '0;
                r_issue_cnt <= '0;
                r_exc_count <= '0;
                r_flag      <= '0;
                r_overrun   <= 1'b0;
            end else begin
                if (w_issue_acc) r_issue_cnt <= r_issue_cnt + 1'b1;
                if ((r_state == ST_DRAIN) && issue_valid) r_overrun <= 1'b1;
                if (w_capture) begin
                    r_flag[r_wr_ptr[AW-1:0]] <= res_exc;
                    r_wr_ptr                 <= r_wr_ptr + 1'b1;
                    r_exc_count              <= r_exc_count + (AW+1)'(res_exc);
                end
            end
        end
    end

    // Result bank write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_capture) r_bank[r_wr_ptr[AW-1:0]] <= res_data;
    end

    // Registered read port; a same-cycle write returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
            r_rd_exc  <= 1'b0;
        end else begin
            r_rd_data <= r_bank[rd_addr];
            r_rd_exc  <= r_flag[rd_addr];
        end
    end

    assign rd_data       = r_rd_data;
    assign rd_exc        = r_rd_exc;
    assign exc_count     = r_exc_count;
    assign issue_overrun = r_overrun;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_vec_result_collector.sv
// Randomised bench for vec_result_collector with a scoreboard model of the
// collection rules and a few hand-computed expectations.
module tb_vec_result_collector;

    localparam int VL  = 32;
    localparam int LT  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        issue_valid = 1'b0;
    logic [31:0] res_data = 32'h0;
    logic        res_exc = 1'b0;
    logic [4:0]  rd_addr = 5'd0;
    logic [31:0] rd_data;
    logic        rd_exc;
    logic [5:0]  exc_count;
    logic        issue_overrun;
    logic        busy;
    logic        done;

    vec_result_collector dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .issue_valid   (issue_valid),
        .res_data      (res_data),
        .res_exc       (res_exc),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_exc        (rd_exc),
        .exc_count     (exc_count),
        .issue_overrun (issue_overrun),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Result bus schedule: value the multiplier presents at a given edge.
    logic [31:0] res_at [int];
    bit          exc_at [int];

    // Scoreboard model.
    int          m_phase = 0;      // 0 idle, 1 collecting, 2 complete
    int          m_issued = 0;
    int          m_capt = 0;
    int          m_exc = 0;
    bit          m_ovr = 1'b0;
    bit          m_live = 1'b0;
    logic [31:0] m_bank [VL];
    bit          m_known [VL];
    bit          m_flag [VL];
    int          pend [$];
    logic [31:0] m_rd_data = 32'h0;
    bit          m_rd_exc = 1'b0;
    bit          m_rd_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < VL; i++) begin
            m_known[i] = 1'b0;
            m_flag[i]  = 1'b0;
            m_bank[i]  = 32'h0;
        end
    end

    // Model update at every edge, from the inputs the DUT samples there.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_phase = 0; m_issued = 0; m_capt = 0; m_exc = 0; m_ovr = 1'b0;
            for (int i = 0; i < VL; i++) m_flag[i] = 1'b0;
            pend.delete();
            m_rd_data = 32'h0; m_rd_exc = 1'b0; m_rd_known = 1'b1;
            m_live = 1'b1;
        end else begin
            m_rd_known = m_known[rd_addr];
            m_rd_data  = m_bank[rd_addr];
            m_rd_exc   = m_flag[rd_addr];
            if (m_phase != 1) begin
                if (start) begin
                    m_phase = 1; m_issued = 0; m_capt = 0; m_exc = 0; m_ovr = 1'b0;
                    for (int i = 0; i < VL; i++) m_flag[i] = 1'b0;
                    pend.delete();
                end
            end else begin
                if (pend.size() > 0 && pend[0] == cyc) begin
                    void'(pend.pop_front());
                    m_bank[m_capt]  = res_data;
                    m_known[m_capt] = 1'b1;
                    m_flag[m_capt]  = res_exc;
                    m_exc += int'(res_exc);
                    m_capt++;
                    if (m_capt == VL) m_phase = 2;
                end
                if (issue_valid) begin
                    if (m_issued < VL) begin
                        m_issued++;
                        pend.push_back(cyc + LT);
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
            end
        end
    end

    // Compare process: all outputs against the model on every cycle.
    always @(negedge clk) begin
        if (m_live) begin
            chk("busy", 32'(busy), 32'(m_phase == 1));
            chk("done", 32'(done), 32'(m_phase == 2));
            chk("exc_count", 32'(exc_count), 32'(m_exc));
            chk("issue_overrun", 32'(issue_overrun), 32'(m_ovr));
            chk("rd_exc", 32'(rd_exc), 32'(m_rd_exc));
            if (m_rd_known) chk("rd_data", rd_data, m_rd_data);
        end
    end

    // One clock of stimulus; an issue schedules its product LAT edges later.
    task automatic step(input logic s, input logic iv, input logic [31:0] d, input logic x);
        int e;
        e = cyc + 1;
        start       = s;
        issue_valid = iv;
        if (iv) begin
            res_at[e + LT] = d;
            exc_at[e + LT] = x;
        end
        res_data = res_at.exists(e) ? res_at[e] : 32'hDEADBEEF;
        res_exc  = exc_at.exists(e) ? exc_at[e] : 1'($urandom_range(0, 1));
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            n++;
        end
        chk("done_within_budget", 32'(done), 32'd1);
    endtask

    task automatic read_all(output int bubbles);
        bubbles = 0;
        for (int i = 0; i < VL; i++) begin
            rd_addr = 5'(i);
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (rd_data == 32'hDEADBEEF) bubbles++;
        end
    endtask

    initial begin
        int nb;
        @(negedge clk);

        // Reset state
        reset = 1'b1;
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_exc_count", 32'(exc_count), 32'd0);

        // Vector 1: 32 back-to-back issues, element i = 1.0 * 2^(i+1)
        $display("vector 1: dense issue");
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < VL; i++) begin
            rd_addr = 5'd0;
            step(1'b0, 1'b1, 32'h40000000 + (32'(i) << 23), 1'b0);
        end
        wait_done(20);
        chk("v1_exc_count", 32'(exc_count), 32'd0);
        rd_addr = 5'd0;  step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("v1_elem0", rd_data, 32'h40000000);
        rd_addr = 5'd31; step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("v1_elem31", rd_data, 32'h4F800000);

        // Vector 2: restart from DONE, 2-cycle gaps every third element,
        // and a start pulse mid-run that must be ignored.
        $display("vector 2: gapped issue");
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < VL; i++) begin
            rd_addr = 5'($urandom_range(0, 31));
            step(1'b0, 1'b0, 32'h0, 1'b0);
            step(i == 10, 1'b1, $urandom, 1'b0);
            if (i % 3 == 2) begin
                step(1'b0, 1'b0, 32'h0, 1'b0);
                step(1'b0, 1'b0, 32'h0, 1'b0);
            end
        end
        wait_done(20);
        read_all(nb);
        chk("v2_no_bubble_data", 32'(nb), 32'd0);

        // Vector 3: exceptions on elements 3, 17, 31
        $display("vector 3: exceptions");
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < VL; i++) begin
            rd_addr = 5'($urandom_range(0, 31));
            step(1'b0, 1'b1, $urandom, (i == 3 || i == 17 || i == 31));
        end
        wait_done(20);
        chk("v3_exc_count", 32'(exc_count), 32'd3);
        for (int i = 0; i < VL; i++) begin
            rd_addr = 5'(i);
            step(1'b0, 1'b0, 32'h0, 1'b0);
            chk("v3_rd_exc", 32'(rd_exc), 32'(i == 3 || i == 17 || i == 31));
        end

        // Vector 4: restart clears counters; 35 issues -> overrun
        $display("vector 4: overrun");
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("v4_busy_after_start", 32'(busy), 32'd1);
        chk("v4_exc_cleared", 32'(exc_count), 32'd0);
        for (int i = 0; i < 35; i++) begin
            rd_addr = 5'($urandom_range(0, 31));
            step(1'b0, 1'b1, $urandom, 1'($urandom_range(0, 1)));
        end
        wait_done(20);
        chk("v4_overrun", 32'(issue_overrun), 32'd1);
        read_all(nb);

        // Vector 5: reset after 10 captures with 4 in flight, then restart
        $display("vector 5: reset mid-run");
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            rd_addr = 5'($urandom_range(0, 31));
            step(1'b0, 1'b1, $urandom, 1'b1);
        end
        reset = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        chk("v5_exc_after_reset", 32'(exc_count), 32'd0);
        chk("v5_done_after_reset", 32'(done), 32'd0);
        chk("v5_busy_after_reset", 32'(busy), 32'd0);
        rd_addr = 5'd0;
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < VL; i++) begin
            rd_addr = 5'($urandom_range(0, 31));
            while ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, 32'h0, 1'b0);
            step(1'b0, 1'b1, $urandom, 1'($urandom_range(0, 1)));
        end
        wait_done(40);
        read_all(nb);
        chk("v5_no_bubble_data", 32'(nb), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
